// File: rtl/gs_bfu_pipe.sv
// gs_bfu_pipe: five-stage Gentleman-Sande butterfly mod 2^27+2^15+1 with optional halving.
// oA = (A+B)*h, oB = (A-B)*W*h; results appear four edges after the capture edge.
module gs_bfu_pipe #(
    parameter int PARAM_Q = 134250497,
    parameter int D       = 28
) (
    input  logic         iSYS_CLK,
    input  logic         iSYS_RST,
    input  logic         iFSM_START,
    input  logic         iHALF,
    input  logic [D-1:0] iA,
    input  logic [D-1:0] iB,
    input  logic [D-1:0] iW,
    output logic [D-1:0] oA,
    output logic [D-1:0] oB,
    output logic         oVALID
);
    localparam int LAT = 5;
    localparam logic [28:0] Q29  = 29'(PARAM_Q);
    localparam logic [43:0] OFF1 = 44'(PARAM_Q) << 16;
    localparam logic [33:0] OFF2 = 34'(PARAM_Q) << 6;

    function automatic logic [D-1:0] halve(input logic [D-1:0] x);
        return x[0] ? D'((29'(x) + Q29) >> 1) : x >> 1;
    endfunction

    logic [D-1:0] s1Sum, s1Diff, s1W, sum2, sum3, sum4, red4;
    logic [3:0]   vldPipe, halfPipe;
    logic [55:0]  prod2;
    logic [43:0]  fold3;
    logic [28:0]  sumRaw, diffRaw, x3;
    logic [33:0]  x2;
    logic [43:0]  fold1;
    logic [D-1:0] sumNext, diffNext, redNext;

    always_comb begin
        sumRaw   = 29'(iA) + 29'(iB);
        diffRaw  = (iA >= iB) ? 29'(iA - iB) : 29'(iA) + Q29 - 29'(iB);
        sumNext  = D'((sumRaw >= Q29) ? sumRaw - Q29 : sumRaw);
        diffNext = D'(diffRaw);
        // 2^27 == -(2^15+1) mod Q; each fold adds a multiple of Q to stay non-negative
        fold1    = 44'(prod2[26:0]) + OFF1 - ((44'(prod2[55:27]) << 15) + 44'(prod2[55:27]));
        x2       = 34'(fold3[26:0]) + OFF2 - ((34'(fold3[43:27]) << 15) + 34'(fold3[43:27]));
        x3       = 29'(x2[26:0]) + Q29 - ((29'(x2[33:27]) << 15) + 29'(x2[33:27]));
        redNext  = D'((x3 >= Q29) ? x3 - Q29 : x3);
    end

    always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
        if (iSYS_RST) begin
            s1Sum    <= '0;
            s1Diff   <= '0;
            s1W      <= '0;
            prod2    <= '0;
            fold3    <= '0;
            red4     <= '0;
            sum2     <= '0;
            sum3     <= '0;
            sum4     <= '0;
            vldPipe  <= '0;
            halfPipe <= '0;
            oA       <= '0;
            oB       <= '0;
            oVALID   <= 1'b0;
        end else begin
            if (iFSM_START) begin
                s1Sum  <= sumNext;
                s1Diff <= diffNext;
                s1W    <= iW;
            end
            vldPipe  <= {vldPipe[2:0], iFSM_START};
            halfPipe <= {halfPipe[2:0], iFSM_START & iHALF};
            prod2    <= 56'(s1Diff) * 56'(s1W);
            fold3    <= fold1;
            red4     <= redNext;
            sum2     <= s1Sum;
            sum3     <= sum2;
            sum4     <= sum3;
            oA       <= halfPipe[3] ? halve(sum4) : sum4;
            oB       <= halfPipe[3] ? halve(red4) : red4;
            oVALID   <= vldPipe[3];
        end
    end
endmodule

// File: tb/tb_gs_bfu_pipe.sv
// tb_gs_bfu_pipe: directed and random scoreboard bench for gs_bfu_pipe.
module tb_gs_bfu_pipe;
    localparam longint unsigned Q = 134250497;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        half = 1'b0;
    logic [27:0] a = '0, b = '0, w = '0;
    logic [27:0] oA, oB;
    logic        oVALID;

    typedef struct {
        logic [27:0] ea;
        logic [27:0] eb;
        int          cap;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    gs_bfu_pipe dut (
        .iSYS_CLK(clk), .iSYS_RST(rst), .iFSM_START(start), .iHALF(half),
        .iA(a), .iB(b), .iW(w), .oA(oA), .oB(oB), .oVALID(oVALID)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint unsigned ma, mb, mw, input bit mh, input int cap);
        longint unsigned h, s, d, p;
        exp_t e;
        h = mh ? (Q + 1) / 2 : 1;
        s = (ma + mb) % Q;
        d = (ma + Q - mb) % Q;
        p = (d * mw) % Q;
        e.ea = 28'((s * h) % Q);
        e.eb = 28'((p * h) % Q);
        e.cap = cap;
        return e;
    endfunction

    task automatic step(input bit v, input logic [27:0] ta, tb, tw, input bit th);
        start = v;
        a = ta;
        b = tb;
        w = tw;
        half = th;
        if (v) sb.push_back(model(ta, tb, tw, th, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && oVALID) begin
            if (sb.size() == 0) chk("stray_valid", oVALID, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cap + 4);
                chk("oA", oA, e.ea);
                chk("oB", oB, e.eb);
            end
        end
    end

    initial begin
        logic [27:0] ra, rb, rw;
        #12;
        chk("rst_valid", oVALID, 0);
        chk("rst_oA", oA, 0);
        chk("rst_oB", oB, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
            #4;
            chk("idle_valid", oVALID, 0);
            chk("idle_oA", oA, 0);
            chk("idle_oB", oB, 0);
        end
        // single basic op, then streaming with a gap
        step(1'b1, 28'd5, 28'd3, 28'd1, 1'b0);
        repeat (6) step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
        step(1'b1, 28'd3, 28'd5, 28'd1, 1'b0);
        step(1'b1, 28'd134250496, 28'd1, 28'd2, 1'b0);
        step(1'b1, 28'd1, 28'd0, 28'd1, 1'b1);
        step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
        step(1'b1, 28'd4, 28'd2, 28'd3, 1'b1);
        step(1'b1, 28'd77, 28'd77, 28'd12345, 1'b0);
        step(1'b1, 28'd1000, 28'd999, 28'd0, 1'b1);
        step(1'b1, 28'd134250496, 28'd134250496, 28'd134250496, 1'b1);
        step(1'b1, 28'd0, 28'd1, 28'd134250496, 1'b0);
        repeat (8) step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
        // reset mid-flight
        step(1'b1, 28'd11, 28'd22, 28'd33, 1'b0);
        step(1'b1, 28'd44, 28'd55, 28'd66, 1'b1);
        step(1'b1, 28'd77, 28'd88, 28'd99, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_valid", oVALID, 0);
        chk("midrst_oA", oA, 0);
        chk("midrst_oB", oB, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (6) step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
        step(1'b1, 28'd5, 28'd3, 28'd1, 1'b0);
        repeat (6) step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
        // random run against the modular model
        for (int i = 0; i < 10000; i++) begin
            ra = 28'($urandom_range(134250496));
            rb = (i % 17 == 0) ? ra : 28'($urandom_range(134250496));
            rw = (i % 13 == 0) ? 28'd134250496 : 28'($urandom_range(134250496));
            step($urandom_range(9) != 0, ra, rb, rw, 1'($urandom_range(1)));
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 28'd0, 28'd0, 28'd0, 1'b0);
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gs_bfu_pipe.md
# gs_bfu_pipe

Pipelined Gentleman-Sande butterfly for the inverse NTT datapath. It is the inverse-direction counterpart of the Cooley-Tukey butterfly used in the forward NTT. It accepts one coefficient pair plus twiddle per cycle and returns the sum and the twiddle-weighted difference modulo PARAM_Q five register stages later. An optional per-operand halving folds the n^-1 scaling into the final INTT layer.

## Interface
- PARAM_Q, 134250497, modulus (2^27 + 2^15 + 1); all operands and results lie in [0, PARAM_Q-1]
- D, 28, coefficient width in bits
- LAT, 5, pipeline depth in register stages; fixed, not user-tunable
- iSYS_CLK  in  1  system clock; all state updates on the rising edge
- iSYS_RST  in  1  asynchronous, active-high reset
- iFSM_START  in  1  input-valid strobe; when high, the operands are captured at this edge
- iHALF  in  1  when 1, both results are multiplied by 2^-1 mod PARAM_Q
- iA  in  D  upper coefficient
- iB  in  D  lower coefficient
- iW  in  D  twiddle factor (inverse root power)
- oA  out  D  (A+B)·h mod PARAM_Q
- oB  out  D  (A−B)·W·h mod PARAM_Q
- oVALID  out  1  high for exactly one cycle per accepted input, LAT stages after capture

Here h = 1, or h = (PARAM_Q+1)/2 when iHALF = 1.

## Operation
- There is no stall and no backpressure. The pipeline advances every cycle, and a valid bit travels alongside the data.
- Stage 1 (capture):
  - S = A+B; if S ≥ Q then S −= Q.
  - Dd = A−B; if negative then Dd += Q.
  - Register S, Dd, W, iHALF, and the valid bit.
- Stages 2–4:
  - Compute the 2D-bit product P = Dd·W.
  - Reduce P mod Q. The implementation may use Barrett or a special-form fold exploiting Q = 2^27+2^15+1.
  - The result must be the exact canonical residue in [0, Q−1].
  - Sum S, the halving flag, and the valid bit are delayed in matching shift registers.
- Stage 5 (halve and output):
  - Halving of x ∈ [0, Q−1]: the result is x>>1 if x is even, else (x+Q)>>1. No multiplier is used.
  - Apply halving to both S and the reduced product when the flag is set.
  - Register the results into oA, oB, and oVALID.
- Input contract: iA, iB, iW < PARAM_Q. Behaviour for non-canonical inputs is unspecified, and the bench must not drive them.
- When oVALID = 0, oA and oB are don't-care, except immediately after reset.

## Timing
- Reset (iSYS_RST = 1, asynchronous):
  - All valid bits clear.
  - oVALID = 0, oA = 0, oB = 0.
  - All pipeline data registers clear to 0.
- During reset, iFSM_START is ignored.
- Outputs stay at their reset values until the first capture propagates.
- A capture at rising edge k produces its results on oA, oB, and oVALID = 1 at rising edge k+4. The values are stable for one cycle.
- Throughput is one butterfly per cycle. Back-to-back strobes produce back-to-back oVALID pulses. Gaps in iFSM_START reproduce as identical gaps in oVALID.
- Order is preserved; there is no reordering or coalescing.
- Reset asserted mid-stream:
  - All in-flight operations are discarded.
  - No oVALID pulse may appear for any operand captured before reset.
  - The first capture after deassertion obeys the k+4 rule.
- iHALF is sampled together with the operands at the capture edge. Per-operand changes of iHALF are legal.
- Boundary cases:
  - A = B gives oB = 0 for any W.
  - W = 0 gives oB = 0.
  - A+B = Q gives oA = 0.
  - A−B = −1 gives Dd = Q−1.

## Test plan
- Basic: A=5, B=3, W=1, iHALF=0 → after 5 stages, oA=8, oB=2, oVALID pulse of 1 cycle.
- Negative difference with wraparound: A=3, B=5, W=1 → oA=8, oB=134250495. A=134250496, B=1, W=2 → oA=0, oB=134250493.
- Halving: A=1, B=0, W=1, iHALF=1 → oA=67125249, oB=67125249. A=4, B=2, W=3, iHALF=1 → oA=3, oB=3.
- Streaming: strobe on cycles 0, 1, 2, skip 3, strobe on 4, using the vectors above → oVALID high on cycles 4, 5, 6, low on 7, high on 8, each carrying the matching expected result. Also check a random 10^4-vector run against a golden modular model, including W = Q−1 and A = B.
- Reset mid-flight: three strobes, then assert iSYS_RST asynchronously between edges for 2 cycles → oVALID, oA, and oB drop to 0 immediately with no later stale pulses. A fresh A=5, B=3, W=1 returns 8/2 exactly 5 stages after its capture.
- Idle: iFSM_START held low for 20 cycles after reset → oVALID stays 0 and oA = oB = 0 throughout.
